myproject_dense_acc: RTL and testbench

Accumulate-and-requantize stage directly downstream of the 15×9-bit dense-layer multiplier. It consumes the stream of signed 24-bit products, sums N_IN of them with a per-neuron bias, then rounds, optionally applies ReLU, and saturates to the layer output width. Each finished activation is presented on a valid/ready output to the next layer.

---
 rtl/myproject_dense_acc.sv | 159 +++++++++++++++
 tb/tb_myproject_dense_acc.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/myproject_dense_acc.sv
// Accumulate-and-requantize stage for the dense layer.
// Sums N_IN signed products plus a per-neuron bias, then rounds half-up,
// optionally applies ReLU, saturates to OUT_WIDTH and hands the activation
// downstream over a valid/ready pair.
module myproject_dense_acc #(
    parameter int PROD_WIDTH = 24,
    parameter int N_IN       = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int BIAS_WIDTH = 16,
    parameter int SHIFT      = 8,
    parameter int OUT_WIDTH  = 16,
    parameter int RELU       = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PROD_WIDTH-1:0] in_data,
    input  logic [BIAS_WIDTH-1:0] bias_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_sat
);

    localparam int CNT_WIDTH = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(N_IN - 1);

    // Rounding constant and output limits, all at ACC_WIDTH+1 bits so the
    // rounding add can never overflow.
    localparam logic signed [ACC_WIDTH:0] ROUND_HALF = (ACC_WIDTH + 1)'(1) << (SHIFT - 1);
    localparam logic signed [ACC_WIDTH:0] OUT_MAX =
        (ACC_WIDTH + 1)'((longint'(1) <<< (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH:0] OUT_MIN = ~OUT_MAX;

    // Parameter sanity checks, evaluated at elaboration.
    generate
        if (N_IN < 1) begin : g_bad_n_in
            $error("myproject_dense_acc: N_IN must be >= 1");
        end
        if (SHIFT < 1) begin : g_bad_shift
            $error("myproject_dense_acc: SHIFT must be >= 1");
        end
        if (ACC_WIDTH < PROD_WIDTH + $clog2(N_IN) + 1) begin : g_bad_acc
            $error("myproject_dense_acc: ACC_WIDTH too narrow for N_IN products");
        end
        if (BIAS_WIDTH > ACC_WIDTH) begin : g_bad_bias
            $error("myproject_dense_acc: BIAS_WIDTH must not exceed ACC_WIDTH");
        end
        if (OUT_WIDTH > ACC_WIDTH + 1) begin : g_bad_out
            $error("myproject_dense_acc: OUT_WIDTH must not exceed ACC_WIDTH+1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        ROUND = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t                       state_q;
    state_t                       state_d;
    logic [CNT_WIDTH-1:0]         cnt_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;

    logic                         beat;
    logic                         last_beat;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  bias_ext;

    logic signed [ACC_WIDTH:0]    acc_ext;
    logic signed [ACC_WIDTH:0]    rnd_sum;
    logic signed [ACC_WIDTH:0]    rnd;
    logic [OUT_WIDTH-1:0]         q_data;
    logic                         q_sat;

    // Handshake and operand extension.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == OUT);
    assign beat      = in_valid && in_ready;
    assign last_beat = beat && (cnt_q == CNT_LAST);
    assign prod_ext  = ACC_WIDTH'($signed(in_data));
    assign bias_ext  = ACC_WIDTH'($signed(bias_data));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ACCUM;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            state_q <= state_d;
        end
    end

    // Next-state logic: ACCUM until the last beat, one ROUND cycle, then OUT
    // until downstream accepts.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            ACCUM:   if (last_beat) state_d = ROUND;
            ROUND:   state_d = OUT;
            OUT:     if (out_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // Requantization: round half-up, optional ReLU, saturate to OUT_WIDTH.
    always_comb begin
        acc_ext = {acc_q[ACC_WIDTH-1], acc_q};
        rnd_sum = acc_ext + ROUND_HALF;
        rnd     = rnd_sum >>> SHIFT;
        q_data  = rnd[OUT_WIDTH-1:0];
        q_sat   = 1'b0;
        if ((RELU != 0) && rnd[ACC_WIDTH]) begin
            q_data = '0;
        end else if (rnd > OUT_MAX) begin
            q_data = OUT_MAX[OUT_WIDTH-1:0];
            q_sat  = 1'b1;
        end else if (rnd < OUT_MIN) begin
            q_data = OUT_MIN[OUT_WIDTH-1:0];
            q_sat  = 1'b1;
        end
    end

    // Beat counter and accumulator; first beat of a frame loads the bias.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the accumulator is reset too, so a reset mid-frame
            // discards the partial sum and the next beat starts a new frame.
            cnt_q <= '0;
            acc_q <= '0;
        end else if (beat) begin
            if (cnt_q == '0) begin
                acc_q <= bias_ext + prod_ext;
            end else begin
                acc_q <= acc_q + prod_ext;
            end
            if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Output register: captured in ROUND and held through OUT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (state_q == ROUND) begin
            out_data <= q_data;
            out_sat  <= q_sat;
        end
    end

endmodule

// File: tb/tb_myproject_dense_acc.sv
// Bench for myproject_dense_acc: two instances (RELU off / on) share one
// stimulus stream; a frame-level model predicts every activation and when it
// must appear, and directed frames pin known results.
`timescale 1ns/1ps
module tb_myproject_dense_acc;

    localparam int PW = 24;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int BW = 16;
    localparam int SH = 8;
    localparam int OW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [PW-1:0] in_data = '0;
    logic [BW-1:0] bias_data = '0;

    logic          in_ready, out_valid, out_sat;
    logic [OW-1:0] out_data;
    logic          r_in_ready, r_out_valid, r_out_sat;
    logic [OW-1:0] r_out_data;

    int vectors = 0;
    int miscompares = 0;
    bit rand_or = 1'b0;
    int cyc = 0;
    int lat;
    int rp[N];
    int rb;

    always #5 clk = ~clk;

    myproject_dense_acc #(
        .PROD_WIDTH(PW), .N_IN(N), .ACC_WIDTH(AW), .BIAS_WIDTH(BW),
        .SHIFT(SH), .OUT_WIDTH(OW), .RELU(0)
    ) u_dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .bias_data(bias_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
    );

    myproject_dense_acc #(
        .PROD_WIDTH(PW), .N_IN(N), .ACC_WIDTH(AW), .BIAS_WIDTH(BW),
        .SHIFT(SH), .OUT_WIDTH(OW), .RELU(1)
    ) u_relu (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(r_in_ready), .in_data(in_data), .bias_data(bias_data),
        .out_valid(r_out_valid), .out_ready(out_ready), .out_data(r_out_data), .out_sat(r_out_sat)
    );

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requantization rule expressed with plain integer arithmetic.
    function automatic void model(input longint sum, input bit relu,
                                  output longint d, output bit s);
        longint r;
        longint omax;
        omax = (longint'(1) <<< (OW - 1)) - 1;
        r = (sum + (longint'(1) <<< (SH - 1))) >>> SH;
        s = 1'b0;
        d = r;
        if (relu && r < 0) begin
            d = 0;
        end else if (r > omax) begin
            d = omax;
            s = 1'b1;
        end else if (r < -omax - 1) begin
            d = -omax - 1;
            s = 1'b1;
        end
    endfunction

    // Frame-level scoreboard: a result is due two cycles after the last beat,
    // stays valid until taken, and no beat is accepted while it is pending.
    longint m_sum;
    int     m_beats = 0;
    bit     have_exp = 1'b0;
    int     due = 0;
    longint e_d, e_rd;
    bit     e_s, e_rs;
    bit     ev, acc_ok;

    always @(negedge clk) begin
        if (!reset_n) begin
            m_beats  = 0;
            have_exp = 1'b0;
        end else begin
            ev     = have_exp && (cyc >= due);
            acc_ok = !have_exp;
            check("out_valid", longint'(out_valid), longint'(ev));
            check("relu out_valid", longint'(r_out_valid), longint'(ev));
            check("in_ready", longint'(in_ready), longint'(acc_ok));
            check("relu in_ready", longint'(r_in_ready), longint'(acc_ok));
            if (ev) begin
                check("out_data", longint'($signed(out_data)), e_d);
                check("out_sat", longint'(out_sat), longint'(e_s));
                check("relu out_data", longint'($signed(r_out_data)), e_rd);
                check("relu out_sat", longint'(r_out_sat), longint'(e_rs));
                if (out_ready) have_exp = 1'b0;
            end
            if (in_valid && acc_ok) begin
                if (m_beats == 0) m_sum = longint'($signed(bias_data));
                m_sum += longint'($signed(in_data));
                m_beats++;
                if (m_beats == N) begin
                    model(m_sum, 1'b0, e_d, e_s);
                    model(m_sum, 1'b1, e_rd, e_rs);
                    have_exp = 1'b1;
                    due      = cyc + 2;
                    m_beats  = 0;
                end
            end
        end
        cyc++;
    end

    // Advance one cycle; in random mode out_ready toggles randomly.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_or) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_beat(input int d, input int b);
        int n;
        n = 0;
        in_valid  = 1'b1;
        in_data   = d[PW-1:0];
        bias_data = b[BW-1:0];
        forever begin
            @(negedge clk);
            if (in_ready || n >= 200) break;
            tick();
            n++;
        end
        if (n >= 200) check("beat accept timeout", longint'(n), 0);
        tick();
    endtask

    task automatic send_frame(input int b, input int p[N], input int max_gap);
        int gap;
        for (int i = 0; i < N; i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) begin
                in_valid = 1'b0;
                in_data  = PW'($urandom);
                tick();
            end
            send_beat(p[i], (i == 0) ? b : int'($urandom));
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input longint ed, input longint es,
                               input longint erd, input longint ers, output int l);
        l = 0;
        do begin
            @(negedge clk);
            l++;
        end while (!out_valid && l < 100);
        check({name, " valid"}, longint'(out_valid), 1);
        check({name, " data"}, longint'($signed(out_data)), ed);
        check({name, " sat"}, longint'(out_sat), es);
        check({name, " relu data"}, longint'($signed(r_out_data)), erd);
        check({name, " relu sat"}, longint'(r_out_sat), ers);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("reset out_valid", longint'(out_valid), 0);
        check("reset out_data", longint'($signed(out_data)), 0);
        check("reset out_sat", longint'(out_sat), 0);
        check("reset relu out_data", longint'($signed(r_out_data)), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        check("in_ready after reset", longint'(in_ready), 1);
    endtask

    initial begin
        #1;
        check("por out_valid", longint'(out_valid), 0);
        check("por out_data", longint'($signed(out_data)), 0);
        check("por out_sat", longint'(out_sat), 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        check("in_ready after por", longint'(in_ready), 1);

        // Basic sum and latency.
        send_frame(0, '{256, 512, -128, 384}, 0);
        wait_result("basic", 4, 0, 4, 0, lat);
        check("latency", longint'(lat), 2);
        tick();
        send_frame(512, '{0, 0, 0, 0}, 0);
        wait_result("bias only", 2, 0, 2, 0, lat);
        tick();

        // Rounding.
        send_frame(0, '{128, 0, 0, 0}, 0);
        wait_result("round +half", 1, 0, 1, 0, lat);
        tick();
        send_frame(0, '{-128, 0, 0, 0}, 0);
        wait_result("round -half", 0, 0, 0, 0, lat);
        tick();
        send_frame(0, '{-129, 0, 0, 0}, 0);
        wait_result("round below -half", -1, 0, 0, 0, lat);
        tick();

        // Saturation.
        send_frame(0, '{8388607, 8388607, 8388607, 8388607}, 0);
        wait_result("sat max", 32767, 1, 32767, 1, lat);
        tick();
        send_frame(0, '{-8388608, -8388608, -8388608, -8388608}, 0);
        wait_result("sat min", -32768, 1, 0, 0, lat);
        tick();

        // Gaps between beats.
        send_frame(-300, '{1000, -50, 700, 20}, 3);
        wait_result("gaps", 5, 0, 5, 0, lat);
        tick();

        // Backpressure with a beat waiting upstream.
        out_ready = 1'b0;
        send_frame(0, '{25600, 0, 0, 0}, 0);
        wait_result("backpressure", 100, 0, 100, 0, lat);
        in_valid  = 1'b1;
        in_data   = PW'(-25600);
        bias_data = '0;
        repeat (5) begin
            tick();
            @(negedge clk);
            check("held out_data", longint'($signed(out_data)), 100);
            check("held in_ready", longint'(in_ready), 0);
        end
        out_ready = 1'b1;
        send_frame(0, '{-25600, 0, 0, 0}, 0);
        wait_result("after backpressure", -100, 0, 0, 0, lat);
        tick();

        // Reset in the middle of a frame.
        send_beat(1000, 0);
        send_beat(1000, 0);
        in_valid = 1'b0;
        do_reset();
        send_frame(0, '{256, 256, 256, 256}, 0);
        wait_result("after mid-frame reset", 4, 0, 4, 0, lat);
        tick();

        // Randomized frames with random gaps and random out_ready.
        rand_or = 1'b1;
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0)
                    rp[i] = int'($signed(PW'($urandom)));
                else
                    rp[i] = int'($urandom_range(0, 4000)) - 2000;
            end
            rb = int'($signed(BW'($urandom)));
            send_frame(rb, rp, 2);
        end
        rand_or   = 1'b0;
        out_ready = 1'b1;
        repeat (20) tick();
        check("drained", longint'(have_exp), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
